// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered CHANNELS:1 multiplexer with a manual-select mode
// and an auto-scan mode that dwells DWELL enabled cycles on each channel.
// All outputs are registered; ena low freezes state and gates the strobes.
module mux_scan_sel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int DWELL    = 8,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel_in,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SELW-1:0]           sel_out,
    output logic                      dout_valid,
    output logic                      scan_wrap
);

    localparam int SELW1 = SELW + 1;
    localparam int CNTW  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNTW-1:0]  LAST_CNT = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0]  LAST_IDX = SELW'(CHANNELS - 1);
    localparam logic [SELW1-1:0] CH_BOUND = SELW1'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  idx_q, idx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             pend_q, pend_d;    // a wrap happened; flag it with the next channel-0 sample
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             manual_step_s;
    logic             scan_step_s;
    logic             scan_entry_s;
    logic [SELW-1:0]  scan_idx_s;
    logic [CNTW-1:0]  scan_cnt_s;
    logic             scan_pend_s;

    // Return channel idx of the packed bus; out-of-range indices give zero.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [CHANNELS*WIDTH-1:0] bus,
        input logic [SELW-1:0]           idx
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SELW'(k)) begin
                res = bus[k*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    // State register and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            dout_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state, scan position and output-register next values.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        dout_d        = dout_q;
        sel_d         = sel_q;
        valid_d       = 1'b0;
        wrap_d        = 1'b0;
        manual_step_s = 1'b0;
        scan_step_s   = 1'b0;
        scan_entry_s  = 1'b0;

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    // Leaving idle only arms the chosen mode; no sample yet.
                    if (mode) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_MANUAL;
                    end
                end
                ST_MANUAL: begin
                    if (mode) begin
                        // The switching edge already produces the channel-0 sample.
                        state_d      = ST_SCAN;
                        scan_step_s  = 1'b1;
                        scan_entry_s = 1'b1;
                    end else begin
                        manual_step_s = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (mode) begin
                        scan_step_s = 1'b1;
                    end else begin
                        state_d       = ST_MANUAL;
                        manual_step_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A fresh scan starts at channel 0, dwell 0, with no pending wrap.
        if (scan_entry_s) begin
            scan_idx_s  = '0;
            scan_cnt_s  = '0;
            scan_pend_s = 1'b0;
        end else begin
            scan_idx_s  = idx_q;
            scan_cnt_s  = cnt_q;
            scan_pend_s = pend_q;
        end

        if (manual_step_s) begin
            sel_d = sel_in;
            if ({1'b0, sel_in} < CH_BOUND) begin
                dout_d  = pick_channel(din, sel_in);
                valid_d = 1'b1;
            end else begin
                dout_d  = '0;
                valid_d = 1'b0;
            end
        end else if (scan_step_s) begin
            dout_d  = pick_channel(din, scan_idx_s);
            sel_d   = scan_idx_s;
            valid_d = 1'b1;
            wrap_d  = scan_pend_s;
            pend_d  = 1'b0;
            if (scan_cnt_s == LAST_CNT) begin
                cnt_d = '0;
                if (scan_idx_s == LAST_IDX) begin
                    idx_d  = '0;
                    pend_d = 1'b1;
                end else begin
                    idx_d = scan_idx_s + SELW'(1);
                end
            end else begin
                cnt_d = scan_cnt_s + CNTW'(1);
                idx_d = scan_idx_s;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    assign dout       = dout_q;
    assign sel_out    = sel_q;
    assign dout_valid = valid_q;
    assign scan_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: a 4-channel DWELL=3 instance and a
// 3-channel DWELL=1 instance driven from one linear stimulus sequence.
module tb_mux_scan_sel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pos   = 0;

    logic        a_rst, a_ena, a_mode;
    logic [1:0]  a_sel;
    logic [15:0] a_din;
    logic [3:0]  a_dout;
    logic [1:0]  a_selo;
    logic        a_valid, a_wrap;

    logic        b_rst, b_ena, b_mode;
    logic [1:0]  b_sel;
    logic [11:0] b_din;
    logic [3:0]  b_dout;
    logic [1:0]  b_selo;
    logic        b_valid, b_wrap;

    logic [3:0] ch_a [4];

    mux_scan_sel #(.CHANNELS(4), .WIDTH(4), .DWELL(3)) dut_a (
        .clk(clk), .rst(a_rst), .ena(a_ena), .mode(a_mode), .sel_in(a_sel),
        .din(a_din), .dout(a_dout), .sel_out(a_selo),
        .dout_valid(a_valid), .scan_wrap(a_wrap)
    );

    mux_scan_sel #(.CHANNELS(3), .WIDTH(4), .DWELL(1)) dut_b (
        .clk(clk), .rst(b_rst), .ena(b_ena), .mode(b_mode), .sel_in(b_sel),
        .din(b_din), .dout(b_dout), .sel_out(b_selo),
        .dout_valid(b_valid), .scan_wrap(b_wrap)
    );

    function automatic logic [7:0] pk(input logic [3:0] d, input logic [1:0] s,
                                      input logic v, input logic w);
        return {d, s, v, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed {dout,sel,valid,wrap}=%h expected %h", tag, obs, exp);
        end
    endtask

    // Enabled scan steps on dut_a; pos counts samples since the scan was entered.
    task automatic scan_steps(input int n, input string tag);
        int s;
        for (int i = 0; i < n; i++) begin
            step();
            s = (pos / 3) % 4;
            check(tag, {a_dout, a_selo, a_valid, a_wrap},
                  pk(ch_a[s], 2'(s), 1'b1, (pos > 0) && (pos % 12 == 0)));
            pos++;
        end
    endtask

    initial begin
        ch_a[0] = 4'h3; ch_a[1] = 4'hC; ch_a[2] = 4'h5; ch_a[3] = 4'hA;
        a_rst = 1'b1; a_ena = 1'b1; a_mode = 1'b0; a_sel = 2'd2; a_din = 16'hA5C3;
        b_rst = 1'b1; b_ena = 1'b0; b_mode = 1'b0; b_sel = 2'd0; b_din = 12'h5C3;

        // Reset held three cycles with non-zero din
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", {a_dout, a_selo, a_valid, a_wrap}, 8'h00);
        end
        a_rst = 1'b0;
        step();
        check("idle_exit", {a_dout, a_selo, a_valid, a_wrap}, 8'h00);
        step();
        check("first_valid", {a_dout, a_selo, a_valid, a_wrap}, pk(4'h5, 2'd2, 1'b1, 1'b0));

        // Manual sweep 0..3
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            step();
            check("manual_sweep", {a_dout, a_selo, a_valid, a_wrap},
                  pk(ch_a[i], 2'(i), 1'b1, 1'b0));
        end

        // Scan: two full periods plus the re-entry of channel 0
        a_mode = 1'b1;
        pos = 0;
        scan_steps(25, "scan_period");
        scan_steps(3, "scan_to_ch1");          // pos 25,26 on ch0, pos 27 first ch1

        // Freeze for 5 cycles in the middle of channel 1's dwell
        a_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("freeze", {a_dout, a_selo, a_valid, a_wrap}, pk(4'hC, 2'd1, 1'b0, 1'b0));
        end
        a_ena = 1'b1;
        scan_steps(3, "resume");               // ch1, ch1, then ch2

        // Switch to manual during channel 2
        a_mode = 1'b0;
        a_sel = 2'd1;
        step();
        check("to_manual", {a_dout, a_selo, a_valid, a_wrap}, pk(4'hC, 2'd1, 1'b1, 1'b0));

        // Back to scan: restarts at channel 0, run into channel 3
        a_mode = 1'b1;
        pos = 0;
        scan_steps(10, "rescan");

        // Reset for one cycle during channel 3
        a_rst = 1'b1;
        step();
        check("mid_reset", {a_dout, a_selo, a_valid, a_wrap}, 8'h00);
        a_rst = 1'b0;
        step();
        check("post_reset_idle", {a_dout, a_selo, a_valid, a_wrap}, 8'h00);
        pos = 0;
        scan_steps(1, "post_reset_scan");

        // Three-channel instance: out-of-range manual select, then scan wrap 2->0
        b_rst = 1'b0; b_ena = 1'b1; b_mode = 1'b0; b_sel = 2'd3;
        step();
        check("b_idle_exit", {b_dout, b_selo, b_valid, b_wrap}, 8'h00);
        step();
        check("b_sel_oob", {b_dout, b_selo, b_valid, b_wrap}, pk(4'h0, 2'd3, 1'b0, 1'b0));
        b_sel = 2'd2;
        step();
        check("b_sel_2", {b_dout, b_selo, b_valid, b_wrap}, pk(4'h5, 2'd2, 1'b1, 1'b0));
        b_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic [3:0] exp_d;
            step();
            exp_d = (i % 3 == 0) ? 4'h3 : ((i % 3 == 1) ? 4'hC : 4'h5);
            check("b_scan", {b_dout, b_selo, b_valid, b_wrap},
                  pk(exp_d, 2'(i % 3), 1'b1, (i > 0) && (i % 3 == 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised, registered N-channel multiplexer with a manual-select mode and an auto-scan mode that steps through the channels on a programmable dwell period. It generalises the project's fixed 4:1 combinational mux to CHANNELS inputs of WIDTH bits. It sits between the pin-level `ui_in` field extraction and `uo_out`, and feeds the LED/display logic with one stable channel at a time plus the active channel index.

## Interface

Parameters:
- `CHANNELS`, 4: number of input channels, ≥2.
- `WIDTH`, 4: bits per channel, ≥1.
- `DWELL`, 8: clock cycles spent on each channel in scan mode, ≥1.
- `SELW`, $clog2(CHANNELS): select/index width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  global enable; low freezes all state.
- `mode`  in  1  0 = manual select, 1 = auto-scan.
- `sel_in`  in  SELW  channel index used in manual mode.
- `din`  in  CHANNELS*WIDTH  packed channels; channel k is `din[k*WIDTH +: WIDTH]`.
- `dout`  out  WIDTH  registered selected channel.
- `sel_out`  out  SELW  index of the channel currently in `dout`.
- `dout_valid`  out  1  `dout` holds a legal channel sample.
- `scan_wrap`  out  1  one-cycle pulse when the scan index wraps from CHANNELS-1 to 0.

## Operation

- FSM states: IDLE, MANUAL, SCAN. Reset enters IDLE.
- IDLE → MANUAL when `ena`=1 and `mode`=0. IDLE → SCAN when `ena`=1 and `mode`=1.
- MANUAL ↔ SCAN on a `mode` change, evaluated on every enabled cycle.
- Entering SCAN from any state:
  - scan index = 0, dwell counter = 0.
  - The first sample is channel 0.
- MANUAL:
  - Every enabled cycle, `dout` ← channel `sel_in`, `sel_out` ← `sel_in`, `dout_valid` ← 1.
  - If `sel_in` ≥ CHANNELS (possible when CHANNELS is not a power of two): `dout` ← 0, `sel_out` ← `sel_in`, `dout_valid` ← 0.
- SCAN:
  - Every enabled cycle, `dout` ← channel[scan index], `sel_out` ← scan index, `dout_valid` ← 1.
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1 the counter clears and the scan index advances by 1.
  - From CHANNELS-1 the index wraps to 0, and `scan_wrap` is 1 in the cycle after the wrap edge, i.e. alongside the first channel-0 output.
  - `sel_in` is ignored in SCAN.
  - DWELL=1: the index advances every cycle.
- `ena`=0:
  - FSM, counter, index, `dout` and `sel_out` hold their values.
  - `dout_valid` and `scan_wrap` are 0.
  - When `ena` rises, operation resumes with no lost or repeated dwell cycles.
- `rst` has priority over `ena` and `mode`.

## Timing

- All outputs are registered. Reset value of every output is 0: `dout`, `sel_out`, `dout_valid`, `scan_wrap`.
- Latency is 1 cycle from an input change (`din`, `sel_in`) to `dout` in MANUAL.
- First valid output:
  - Leaving reset with `ena`=1: the first enabled edge only moves IDLE → MANUAL/SCAN, so `dout_valid` is first 1 after the second enabled edge.
  - MANUAL ↔ SCAN transitions take effect on the edge that samples the new `mode`; the following `dout` reflects the new mode.
- Scan period is exactly CHANNELS*DWELL enabled cycles between consecutive `scan_wrap` pulses.
- Reset mid-scan: on the next edge all state returns to the reset values, and the scan restarts at channel 0.
- `din` is sampled every enabled cycle. In SCAN, `dout` tracks changes on the active channel with 1-cycle latency.

## Test plan

- Reset/idle:
  - Stimulus: hold `rst`=1 for 3 cycles with `din`≠0, then release with `ena`=1, `mode`=0, `sel_in`=2, and CHANNELS=4, WIDTH=4 with `din`=16'hA5C3.
  - Required: all outputs stay 0 during reset. After release, `dout`=4'h5, `sel_out`=2, `dout_valid`=1 by the second edge.
- Manual sweep:
  - Stimulus: `sel_in` = 0,1,2,3 on consecutive cycles with `din`=16'hA5C3.
  - Required: `dout` = 3,C,5,A, each one cycle later, with `sel_out` matching.
- Scan with DWELL=3:
  - Stimulus: `mode`=1.
  - Required: `sel_out` follows 0,0,0,1,1,1,2,2,2,3,3,3,0. `scan_wrap` pulses only when channel 0 is re-entered, every 12 cycles.
- Enable freeze:
  - Stimulus: drop `ena` for 5 cycles in the middle of channel 1's dwell.
  - Required: `dout`/`sel_out` are held, `dout_valid`=0, and the remaining channel-1 dwell cycles complete after `ena` returns.
- Mode switch and reset mid-scan:
  - Stimulus: switch to MANUAL during channel 2 with `sel_in`=1, then back to SCAN, then assert `rst` for 1 cycle during channel 3.
  - Required: `sel_out` goes 1 after the switch to MANUAL, restarts at 0 after the switch back to SCAN, and goes to all outputs 0 after `rst`.
- Non-power-of-two, CHANNELS=3:
  - Stimulus: `sel_in`=3 in MANUAL.
  - Required: `dout`=0, `dout_valid`=0. A scan wraps 2 → 0.
